// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard-control unit.
package hazard_pkg;
  localparam int DEF_RA_W  = 5;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } hz_state_t;
endpackage

// File: rtl/hazard_if.sv
// ID/EX hazard request signals and the resulting pipeline control outputs.
interface hazard_if #(parameter int RA_W = hazard_pkg::DEF_RA_W);
  logic            idex_ld;
  logic [RA_W-1:0] idex_rd;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_mdu_start;
  logic            id_mdu_read;
  logic            ex_branch_taken;
  logic            pcwrite;
  logic            ifidwrite;
  logic            idex_bubble;
  logic            ifid_flush;
  logic            mdu_busy;

  modport master (
    output idex_ld, idex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
           id_mdu_start, id_mdu_read, ex_branch_taken,
    input  pcwrite, ifidwrite, idex_bubble, ifid_flush, mdu_busy
  );

  modport slave (
    input  idex_ld, idex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
           id_mdu_start, id_mdu_read, ex_branch_taken,
    output pcwrite, ifidwrite, idex_bubble, ifid_flush, mdu_busy
  );
endinterface

// File: rtl/hazard_mdu_timer.sv
// Busy timer for an in-flight MDU op: loads LAT on issue, counts down to zero.
module hazard_mdu_timer #(
    parameter int LAT   = 32,
    parameter int CNT_W = hazard_pkg::DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(LAT);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_unit.sv
// Load-use / MDU / taken-branch hazard control for the 5-stage core.
// Optional MDU tracking is built only when HAZARD_MDU_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W       = DEF_RA_W,
    parameter int LOAD_STALL = 1,
    parameter int MDU_LAT    = 32,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);
    hz_state_t        state, state_nx;
    logic [CNT_W-1:0] ld_cnt, ld_cnt_nx;
    logic             ld_hit, ld_stall, mdu_hazard, stall, busy;

    assign ld_hit = hz.idex_ld && (hz.idex_rd != '0) &&
                    ((hz.id_use_rs && (hz.id_rs == hz.idex_rd)) ||
                     (hz.id_use_rt && (hz.id_rt == hz.idex_rd)));

    // Once in LD_STALL the EX stage holds a bubble, so the compare is not needed.
    assign ld_stall = (state == LD_STALL) || ld_hit;

`ifdef HAZARD_MDU_EN
    hazard_mdu_timer #(.LAT(MDU_LAT), .CNT_W(CNT_W)) u_mdu_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hz.id_mdu_start && !stall && !hz.ex_branch_taken),
        .busy  (busy)
    );
    assign mdu_hazard = (hz.id_mdu_read || hz.id_mdu_start) && busy;
`else
    logic unused_mdu;
    assign unused_mdu = ^{hz.id_mdu_start, hz.id_mdu_read, CNT_W'(MDU_LAT)};
    assign busy       = 1'b0;
    assign mdu_hazard = 1'b0;
`endif

    assign stall = ld_stall || mdu_hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ld_cnt <= '0;
        end else begin
            state  <= state_nx;
            ld_cnt <= ld_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ld_cnt_nx = ld_cnt;
        if (hz.ex_branch_taken) begin
            state_nx  = IDLE;
            ld_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_hit && (LOAD_STALL > 1)) begin
                        state_nx  = LD_STALL;
                        ld_cnt_nx = CNT_W'(LOAD_STALL - 1);
                    end
                end
                LD_STALL: begin
                    ld_cnt_nx = ld_cnt - 1'b1;
                    if (ld_cnt == CNT_W'(1))
                        state_nx = IDLE;
                end
                default: begin
                    state_nx  = IDLE;
                    ld_cnt_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        hz.pcwrite     = 1'b1;
        hz.ifidwrite   = 1'b1;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.mdu_busy    = busy && rst_n;
        if (!rst_n) begin
            hz.pcwrite     = 1'b0;
            hz.ifidwrite   = 1'b0;
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b1;
        end else if (stall) begin
            hz.pcwrite     = 1'b0;
            hz.ifidwrite   = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end
endmodule
